// File: rtl/m_stage_pkg.sv
// ---------------------------------------------------------------------------
// m_stage_pkg
// Shared types for the M-stage memory interface with posted write buffer.
//   mem_mode_e   : Control -> M stage access type (11 behaves as none)
//   mem_busy_e   : SDRAM controller ownership indication
//   mem_op_e     : M stage -> SDRAM controller request
//   mstg_state_e : M-stage SDRAM sequencing FSM states
// ---------------------------------------------------------------------------
package m_stage_pkg;

    typedef enum logic [1:0] {
        MODE_NONE  = 2'b00,
        MODE_READ  = 2'b01,
        MODE_WRITE = 2'b10,
        MODE_RSVD  = 2'b11
    } mem_mode_e;

    typedef enum logic [1:0] {
        BUSY_IDLE  = 2'b00,
        BUSY_CPU   = 2'b01,
        BUSY_SPART = 2'b10,
        BUSY_AUDIO = 2'b11
    } mem_busy_e;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10
    } mem_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_BUSY = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_BUSY = 3'd4,
        ST_RD_DONE = 3'd5
    } mstg_state_e;

endpackage

// File: rtl/wb_cam_fifo.sv
// ---------------------------------------------------------------------------
// wb_cam_fifo
// Circular FIFO of {address, data} store entries with a content-addressable
// youngest-match lookup used for store-to-load forwarding.
//   clk, rst_n          : clock, async active-low reset (empties the buffer)
//   push, push_addr/data: enqueue at tail (caller guarantees not full)
//   pop                 : retire head entry (caller guarantees not empty)
//   lookup_addr         : address searched against valid entries
//   full, empty, count  : occupancy
//   head_addr/head_data : oldest entry, presented to the drain logic
//   hit, hit_data       : youngest matching entry, combinational
// ---------------------------------------------------------------------------
module wb_cam_fifo #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          lookup_addr,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [ADDR_W-1:0]          head_addr,
    output logic [DATA_W-1:0]          head_data,
    output logic                       hit,
    output logic [DATA_W-1:0]          hit_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            valid <= '0;
        end else begin
            // Clear on pop before set on push so a reused slot ends up valid.
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= push_addr;
            data_mem[tail] <= push_data;
        end
    end

    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;
    assign head_addr = addr_mem[head];
    assign head_data = data_mem[head];

    // Walk oldest to youngest from the head so the last match wins. The head
    // is skipped while it is being popped: its data is already in SDRAM.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (valid[idx] && (addr_mem[idx] == lookup_addr) && !(pop && (i == 0))) begin
                hit      = 1'b1;
                hit_data = data_mem[idx];
            end
        end
    end

endmodule

// File: rtl/mem_stage_wb.sv
// ---------------------------------------------------------------------------
// mem_stage_wb
// M-stage memory interface with a posted write buffer. Stores retire into the
// buffer without waiting for SDRAM; loads hitting a buffered store forward
// from the youngest match; load misses go to SDRAM ahead of queued stores.
//   clk, rst_n            : clock, async active-low reset
//   mem_mode              : 00 none, 01 read, 10 write, 11 none
//   data_addr, data_in    : CPU address / store data (held while stalled)
//   data_out              : load data to the CPU
//   mem_stall             : Control must hold the M-stage instruction
//   wb_flush              : stall until the write buffer has fully drained
//   wb_count              : occupied write-buffer entries
//   mem_busy              : controller owner: 00 idle, 01 CPU, 10/11 others
//   mem_op                : registered request: 00 none, 01 read, 10 write
//   sdram_addr, sdram_in  : registered request address / write data
//   sdram_out             : read data from the controller
// ---------------------------------------------------------------------------
module mem_stage_wb
    import m_stage_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int WB_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  mem_mode,
    input  logic [ADDR_W-1:0]           data_addr,
    input  logic [DATA_W-1:0]           data_in,
    output logic [DATA_W-1:0]           data_out,
    output logic                        mem_stall,
    input  logic                        wb_flush,
    output logic [$clog2(WB_DEPTH):0]   wb_count,
    input  logic [1:0]                  mem_busy,
    output logic [1:0]                  mem_op,
    output logic [ADDR_W-1:0]           sdram_addr,
    output logic [DATA_W-1:0]           sdram_in,
    input  logic [DATA_W-1:0]           sdram_out
);

    localparam int CW = $clog2(WB_DEPTH) + 1;

    mem_mode_e         mode;
    mem_busy_e         busy;
    mstg_state_e       state;
    mem_op_e           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_q;

    logic              is_load;
    logic              is_store;
    logic              drain_active;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              hit;
    logic [DATA_W-1:0] hit_data;

    assign mode = mem_mode_e'(mem_mode);
    assign busy = mem_busy_e'(mem_busy);

    wb_cam_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (WB_DEPTH)
    ) u_wb (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_addr   (data_addr),
        .push_data   (data_in),
        .pop         (pop),
        .lookup_addr (data_addr),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .hit         (hit),
        .hit_data    (hit_data)
    );

    always_comb begin
        is_load      = (mode == MODE_READ);
        is_store     = (mode == MODE_WRITE);
        drain_active = (state == ST_WR_REQ) || (state == ST_WR_BUSY);
        // Completion is the controller leaving CPU ownership, whoever takes over.
        pop          = (state == ST_WR_BUSY) && (busy != BUSY_CPU);

        mem_stall = 1'b0;
        if (is_load && !hit && (state != ST_RD_DONE))
            mem_stall = 1'b1;
        if (is_store && full)
            mem_stall = 1'b1;
        if (wb_flush && ((count != '0) || drain_active))
            mem_stall = 1'b1;

        // A held store is only enqueued once, on the cycle it is released.
        push = is_store && !mem_stall;

        if (state == ST_RD_DONE)
            data_out = rd_q;
        else if (is_load && hit)
            data_out = hit_data;
        else
            data_out = rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_q    <= OP_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_load && !hit) begin
                        state  <= ST_RD_REQ;
                        op_q   <= OP_READ;
                        addr_q <= data_addr;
                    end else if (!empty) begin
                        state   <= ST_WR_REQ;
                        op_q    <= OP_WRITE;
                        addr_q  <= head_addr;
                        wdata_q <= head_data;
                    end
                end
                ST_WR_REQ: begin
                    if (busy == BUSY_CPU) begin
                        state <= ST_WR_BUSY;
                        op_q  <= OP_NONE;
                    end
                end
                ST_WR_BUSY: begin
                    if (busy != BUSY_CPU)
                        state <= ST_IDLE;
                end
                ST_RD_REQ: begin
                    if (busy == BUSY_CPU) begin
                        state <= ST_RD_BUSY;
                        op_q  <= OP_NONE;
                    end
                end
                ST_RD_BUSY: begin
                    if (busy != BUSY_CPU) begin
                        state <= ST_RD_DONE;
                        rd_q  <= sdram_out;
                    end
                end
                ST_RD_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    op_q  <= OP_NONE;
                end
            endcase
        end
    end

    assign mem_op     = op_q;
    assign sdram_addr = addr_q;
    assign sdram_in   = wdata_q;
    assign wb_count   = count;

endmodule

// File: tb/tb_mem_stage_wb.sv
module tb_mem_stage_wb;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int WB_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mem_mode = 2'b00;
    logic [31:0] data_addr = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        mem_stall;
    logic        wb_flush = 1'b0;
    logic [2:0]  wb_count;
    logic [1:0]  mem_busy = 2'b00;
    logic [1:0]  mem_op;
    logic [31:0] sdram_addr;
    logic [31:0] sdram_in;
    logic [31:0] sdram_out = '0;

    always #5 clk = ~clk;

    mem_stage_wb #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .WB_DEPTH (WB_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_mode   (mem_mode),
        .data_addr  (data_addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .mem_stall  (mem_stall),
        .wb_flush   (wb_flush),
        .wb_count   (wb_count),
        .mem_busy   (mem_busy),
        .mem_op     (mem_op),
        .sdram_addr (sdram_addr),
        .sdram_in   (sdram_in),
        .sdram_out  (sdram_out)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        bit          chk_data;
    } req_t;

    req_t        exp_req[$];
    logic [31:0] exp_load[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          max_count = 0;

    // Controller model state
    logic [31:0] model_mem [logic [31:0]];
    bit          other = 1'b0;
    int          extra = 0;
    int          remain = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // SDRAM controller: grants the CPU the cycle it sees a request and holds
    // ownership for 2+extra cycles; SPART ownership is forced with 'other'.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mem_busy = 2'b00;
                remain   = 0;
            end else if (other) begin
                mem_busy = 2'b10;
            end else if (remain > 0) begin
                mem_busy = 2'b01;
                remain--;
            end else if (mem_op != 2'b00) begin
                mem_busy = 2'b01;
                remain   = 1 + extra;
                if (mem_op == 2'b10)
                    model_mem[sdram_addr] = sdram_in;
                else
                    sdram_out = model_mem.exists(sdram_addr) ? model_mem[sdram_addr] : 32'h0;
            end else begin
                mem_busy = 2'b00;
            end
        end
    end

    // Monitor: compares every completed load and every new SDRAM request
    initial begin
        logic [1:0]  prev_op;
        req_t        e;
        logic [31:0] ld;
        prev_op = 2'b00;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_mode == 2'b01 && !mem_stall) begin
                    if (exp_load.size() == 0) begin
                        timeout("unexpected_load_completion");
                    end else begin
                        ld = exp_load.pop_front();
                        check("load_data", data_out, ld);
                    end
                end
                if (mem_op != 2'b00 && prev_op == 2'b00) begin
                    if (exp_req.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_req: got op %0d addr 0x%08h required none", mem_op, sdram_addr);
                    end else begin
                        e = exp_req.pop_front();
                        check("req_op", {30'd0, mem_op}, {30'd0, e.op});
                        check("req_addr", sdram_addr, e.addr);
                        if (e.chk_data)
                            check("req_data", sdram_in, e.data);
                    end
                end
                if (int'(wb_count) > max_count)
                    max_count = int'(wb_count);
            end
            prev_op = mem_op;
        end
    end

    function automatic void exp_wr(input logic [31:0] a, input logic [31:0] d);
        req_t r;
        r.op = 2'b10; r.addr = a; r.data = d; r.chk_data = 1'b1;
        exp_req.push_back(r);
    endfunction

    function automatic void exp_rd(input logic [31:0] a);
        req_t r;
        r.op = 2'b01; r.addr = a; r.data = '0; r.chk_data = 1'b0;
        exp_req.push_back(r);
    endfunction

    // Present an access and return at the negedge before the accepting edge.
    task automatic do_access(input logic [1:0] m, input logic [31:0] a, input logic [31:0] d,
                             input string name, output int stalls);
        bit done;
        stalls = 0;
        done   = 1'b0;
        @(posedge clk);
        #2;
        mem_mode  = m;
        data_addr = a;
        data_in   = d;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (!mem_stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
        end
        if (!done)
            timeout(name);
    endtask

    task automatic idle();
        @(posedge clk);
        #2;
        mem_mode = 2'b00;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (wb_count == 3'd0 && mem_op == 2'b00 && mem_busy != 2'b01) begin
                done = 1'b1;
                break;
            end
        end
        if (!done)
            timeout(name);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  st;
        int  st5;
        bit  seen;
        bit  done;

        model_mem[32'h400] = 32'h12345678;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_op", {30'd0, mem_op}, 32'd0);
        check("rst_sdram_addr", sdram_addr, 32'd0);
        check("rst_sdram_in", sdram_in, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_wb_count", {29'd0, wb_count}, 32'd0);
        check("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single store, then drain request
        exp_wr(32'h100, 32'hDEADBEEF);
        do_access(2'b10, 32'h100, 32'hDEADBEEF, "store1", st);
        check("store1_stall", st, 0);
        idle();
        @(negedge clk);
        check("store1_count", {29'd0, wb_count}, 32'd1);
        wait_drain("drain1");

        // Fill under SPART ownership, fifth store waits for a retirement
        other = 1'b1;
        for (int i = 0; i < 5; i++)
            exp_wr(32'h10 + i, 32'hA0 + i);
        for (int i = 0; i < 4; i++) begin
            do_access(2'b10, 32'h10 + i, 32'hA0 + i, "fill", st);
            check("fill_stall", st, 0);
        end
        fork
            do_access(2'b10, 32'h14, 32'hA4, "store5", st5);
            begin
                repeat (6) @(posedge clk);
                other = 1'b0;
            end
        join
        check("full_stall_seen", {31'd0, (st5 > 0)}, 32'd1);
        idle();
        @(negedge clk);
        check("count_after_full", {29'd0, wb_count}, 32'd4);
        wait_drain("drain_fill");
        check("count_max_le_depth", {31'd0, (max_count <= WB_DEPTH)}, 32'd1);

        // Youngest-match forwarding
        other = 1'b1;
        exp_wr(32'h200, 32'd1);
        exp_wr(32'h200, 32'd2);
        exp_load.push_back(32'd2);
        do_access(2'b10, 32'h200, 32'd1, "fwd_st1", st);
        do_access(2'b10, 32'h200, 32'd2, "fwd_st2", st);
        do_access(2'b01, 32'h200, 32'd0, "fwd_load", st);
        check("fwd_stall", st, 0);
        check("fwd_no_read", {31'd0, (mem_op == 2'b01)}, 32'd0);
        idle();
        other = 1'b0;
        wait_drain("drain_fwd");

        // Load miss overtakes a queued store
        exp_rd(32'h400);
        exp_wr(32'h300, 32'hCAFE0300);
        exp_load.push_back(32'h12345678);
        do_access(2'b10, 32'h300, 32'hCAFE0300, "miss_store", st);
        do_access(2'b01, 32'h400, 32'd0, "miss_load", st);
        check("miss_stall_cycles", st, 4);
        idle();
        wait_drain("drain_miss");

        // Flush
        exp_wr(32'h500, 32'h55);
        do_access(2'b10, 32'h500, 32'h55, "flush_store", st);
        @(posedge clk);
        #2;
        mem_mode = 2'b00;
        wb_flush = 1'b1;
        st   = 0;
        done = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (!mem_stall) begin
                done = 1'b1;
                break;
            end
            st++;
        end
        if (!done)
            timeout("flush_release");
        check("flush_stalled", {31'd0, (st > 0)}, 32'd1);
        check("flush_count", {29'd0, wb_count}, 32'd0);
        check("flush_mem", model_mem.exists(32'h500) ? model_mem[32'h500] : 32'h0, 32'h55);
        @(posedge clk);
        #2;
        wb_flush = 1'b0;
        wait_drain("drain_flush");

        // Reset while the write is in WR_BUSY
        extra = 4;
        exp_wr(32'h600, 32'h66);
        do_access(2'b10, 32'h600, 32'h66, "rst_store", st);
        idle();
        seen = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (mem_op == 2'b10)
                seen = 1'b1;
            else if (seen && mem_op == 2'b00) begin
                done = 1'b1;
                break;
            end
        end
        if (!done)
            timeout("wr_busy_reach");
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_busy_mem_op", {30'd0, mem_op}, 32'd0);
        check("rst_busy_count", {29'd0, wb_count}, 32'd0);
        check("rst_busy_sdram_addr", sdram_addr, 32'd0);
        mem_mode  = 2'b01;
        data_addr = 32'h700;
        #1;
        check("rst_load_stall", {31'd0, mem_stall}, 32'd1);
        mem_mode = 2'b00;
        extra    = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        check("leftover_reqs", exp_req.size(), 0);
        check("leftover_loads", exp_load.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
